// File: rtl/bit_shift_n_pkg.sv
// Shared constants for the bit_shift_n shifter: mode encodings and the
// run-control state enum.
package bit_shift_pkg;

    localparam logic [1:0] MODE_FILL     = 2'b00;
    localparam logic [1:0] MODE_ROT      = 2'b01;
    localparam logic [1:0] MODE_ARITH    = 2'b10;
    localparam logic [1:0] MODE_FILL_ALT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bit_shift_n_if.sv
// Control/data bundle of the bit_shift_n shifter; master drives requests,
// slave (the shifter) returns register contents and run status.
interface bit_shift_n_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] in;
    logic             in_lsb;
    logic             in_msb;
    logic             load;
    logic             shift;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output in, in_lsb, in_msb, load, shift, start, dir, mode, amount,
        input  out, ser_out, busy, done
    );

    modport slave (
        input  in, in_lsb, in_msb, load, shift, start, dir, mode, amount,
        output out, ser_out, busy, done
    );

endinterface

// File: rtl/bit_shift_n.sv
// Parallel-load shift register with single-step and counted multi-step
// shifting in serial-fill, rotate and arithmetic modes.
module bit_shift_n
    import bit_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    bit_shift_n_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] out_r,   out_s;
    logic             ser_r,   ser_s;
    logic             busy_r,  busy_s;
    logic             done_r,  done_s;
    logic [CNT_W-1:0] cnt_r,   cnt_s;
    logic             dir_r,   dir_s;
    logic [1:0]       mode_r,  mode_s;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] amt_s;
    logic [WIDTH:0]   step_live_s;
    logic [WIDTH:0]   step_run_s;

    // One shift step; result is {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] step_f(
        input logic [WIDTH-1:0] cur,
        input logic             d,
        input logic [1:0]       m,
        input logic             lsb,
        input logic             msb
    );
        logic           fill;
        logic [WIDTH:0] res;
        if (d == 1'b0) begin
            case (m)
                MODE_ROT:                fill = cur[WIDTH-1];
                MODE_ARITH:              fill = 1'b0;
                MODE_FILL, MODE_FILL_ALT: fill = lsb;
                default:                 fill = lsb;
            endcase
            res = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
        end else begin
            case (m)
                MODE_ROT:                fill = cur[0];
                MODE_ARITH:              fill = cur[WIDTH-1];
                MODE_FILL, MODE_FILL_ALT: fill = msb;
                default:                 fill = msb;
            endcase
            res = {cur[0], fill, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Next-state and next-output selection: load > start > shift > hold.
    always_comb begin
        out_s   = out_r;
        ser_s   = ser_r;
        done_s  = 1'b0;
        cnt_s   = cnt_r;
        dir_s   = dir_r;
        mode_s  = mode_r;
        state_s = state_r;
        amt_s   = (bus.amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.amount;
        step_live_s = step_f(out_r, bus.dir, bus.mode, bus.in_lsb, bus.in_msb);
        // A run keeps its latched direction/mode but takes the fill bits live.
        step_run_s  = step_f(out_r, dir_r, mode_r, bus.in_lsb, bus.in_msb);

        if (bus.load) begin
            out_s   = bus.in;
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        dir_s  = bus.dir;
                        mode_s = bus.mode;
                        cnt_s  = amt_s;
                        if (amt_s != {CNT_W{1'b0}}) begin
                            state_s = ST_RUN;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else if (bus.shift) begin
                        {ser_s, out_s} = step_live_s;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    {ser_s, out_s} = step_run_s;
                    cnt_s = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end

        busy_s = (state_s == ST_RUN);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= {WIDTH{1'b0}};
            ser_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            dir_r   <= 1'b0;
            mode_r  <= MODE_FILL;
            state_r <= ST_IDLE;
        end else begin
            out_r   <= out_s;
            ser_r   <= ser_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            cnt_r   <= cnt_s;
            dir_r   <= dir_s;
            mode_r  <= mode_s;
            state_r <= state_s;
        end
    end

    assign bus.out     = out_r;
    assign bus.ser_out = ser_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_bit_shift_n.sv
// Scoreboard bench for bit_shift_n (WIDTH=8): directed scenarios plus random
// traffic, each edge predicted by an arithmetic reference model.
module tb_bit_shift_n;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] o;
        logic         s;
        logic         b;
        logic         d;
    } exp_t;

    logic clk;
    logic rst_n;
    bit_shift_n_if #(.WIDTH(W)) bus ();

    bit_shift_n #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    // Reference model: value as an integer, a run as "steps remaining".
    int m_val, m_ser, m_left, m_done, m_dir, m_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void model_step(input int d, input int m);
        int fill;
        if (d == 0) begin
            if (m == 1) fill = (m_val >> (W - 1)) & 1;
            else if (m == 2) fill = 0;
            else fill = int'(bus.in_lsb);
            m_ser = (m_val >> (W - 1)) & 1;
            m_val = (m_val * 2 + fill) % (1 << W);
        end else begin
            if (m == 1) fill = m_val % 2;
            else if (m == 2) fill = (m_val >> (W - 1)) & 1;
            else fill = int'(bus.in_msb);
            m_ser = m_val % 2;
            m_val = m_val / 2 + fill * (1 << (W - 1));
        end
    endfunction

    function automatic void model_edge();
        int n;
        if (rst_n == 1'b0) begin
            m_val = 0; m_ser = 0; m_left = 0; m_done = 0;
        end else if (bus.load) begin
            m_val = int'(bus.in); m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            model_step(m_dir, m_mode);
            m_left = m_left - 1;
            m_done = (m_left == 0) ? 1 : 0;
        end else if (bus.start) begin
            n = (int'(bus.amount) < W) ? int'(bus.amount) : W;
            m_dir = int'(bus.dir); m_mode = int'(bus.mode);
            m_left = n;
            m_done = (n == 0) ? 1 : 0;
        end else if (bus.shift) begin
            model_step(int'(bus.dir), int'(bus.mode));
            m_done = 0;
        end else begin
            m_done = 0;
        end
    endfunction

    // One clock: predict the post-edge outputs and queue them for the monitor.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.o = W'(m_val);
        e.s = (m_ser != 0);
        e.b = (m_left > 0);
        e.d = (m_done != 0);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compare every registered output set on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", {bus.out, bus.ser_out, bus.busy, bus.done}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, r;
        rst_n = 1'b0;
        bus.in = '0; bus.in_lsb = 1'b0; bus.in_msb = 1'b0;
        bus.load = 1'b0; bus.shift = 1'b0; bus.start = 1'b0;
        bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = '0;
        m_val = 0; m_ser = 0; m_left = 0; m_done = 0; m_dir = 0; m_mode = 0;
        tick(); tick();
        chk("reset_state", {bus.out, bus.ser_out, bus.busy, bus.done}, 11'h000);
        rst_n = 1'b1;

        // Load 0xA5, fill-shift left with in_lsb=1.
        bus.load = 1'b1; bus.in = 8'hA5; tick(); bus.load = 1'b0;
        bus.shift = 1'b1; bus.dir = 1'b0; bus.mode = 2'b00; bus.in_lsb = 1'b1;
        tick(); bus.shift = 1'b0;
        chk("fill_left_out", bus.out, 8'h4B);
        chk("fill_left_ser", bus.ser_out, 1'b1);

        // Load 0x81, rotate right by 3.
        bus.load = 1'b1; bus.in = 8'h81; tick(); bus.load = 1'b0;
        bus.start = 1'b1; bus.dir = 1'b1; bus.mode = 2'b01; bus.amount = 4'd3;
        tick(); bus.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.busy) nb++;
            tick();
        end
        chk("rot_busy_cycles", nb, 3);
        chk("rot_out", bus.out, 8'h30);
        chk("rot_ser", bus.ser_out, 1'b0);
        chk("rot_done", {bus.busy, bus.done}, 2'b01);

        // Load 0x90, arithmetic right by 2; done exactly once.
        bus.load = 1'b1; bus.in = 8'h90; tick(); bus.load = 1'b0;
        bus.start = 1'b1; bus.mode = 2'b10; bus.amount = 4'd2;
        tick(); bus.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) nb++;
        end
        chk("arith_out", bus.out, 8'hE4);
        chk("arith_done_count", nb, 1);

        // Abort a 5-step run with load in the second busy cycle.
        bus.load = 1'b1; bus.in = 8'hFF; tick(); bus.load = 1'b0;
        bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = 4'd5;
        bus.in_lsb = 1'b0;
        tick(); bus.start = 1'b0;
        tick();
        bus.load = 1'b1; bus.in = 8'h3C; tick(); bus.load = 1'b0;
        chk("abort_out", bus.out, 8'h3C);
        chk("abort_busy_done", {bus.busy, bus.done}, 2'b00);
        tick();
        chk("abort_no_done", bus.done, 1'b0);

        // Zero-length run: done next cycle, no busy, value held.
        bus.start = 1'b1; bus.amount = 4'd0; tick(); bus.start = 1'b0;
        chk("zero_run", {bus.out, bus.busy, bus.done}, {8'h3C, 2'b01});
        tick();

        // Amount above WIDTH saturates to 8 steps.
        bus.load = 1'b1; bus.in = 8'hFF; tick(); bus.load = 1'b0;
        bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b10; bus.amount = 4'd12;
        tick(); bus.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy) nb++;
            tick();
        end
        chk("sat_busy_cycles", nb, 8);
        chk("sat_out", bus.out, 8'h00);

        // Asynchronous reset in the middle of a run, then recovery.
        bus.load = 1'b1; bus.in = 8'h81; tick(); bus.load = 1'b0;
        bus.start = 1'b1; bus.dir = 1'b1; bus.mode = 2'b01; bus.amount = 4'd5;
        tick(); bus.start = 1'b0;
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {bus.out, bus.ser_out, bus.busy, bus.done}, 11'h000);
        tick();
        rst_n = 1'b1;
        bus.load = 1'b1; bus.in = 8'h5A; tick(); bus.load = 1'b0;
        chk("post_reset_load", {bus.out, bus.busy, bus.done}, {8'h5A, 2'b00});

        // Random traffic, every edge checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            bus.load   = (r < 6);
            bus.start  = (r >= 6 && r < 30);
            bus.shift  = 1'($urandom_range(0, 1));
            bus.dir    = 1'($urandom_range(0, 1));
            bus.mode   = 2'($urandom_range(0, 3));
            bus.amount = 4'($urandom_range(0, 15));
            bus.in     = 8'($urandom);
            bus.in_lsb = 1'($urandom_range(0, 1));
            bus.in_msb = 1'($urandom_range(0, 1));
            tick();
        end
        bus.load = 1'b0; bus.start = 1'b0; bus.shift = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bit_shift_n.md
BIT_SHIFT_N -- requirements
Module: bit_shift_n

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 Localparam CNT_W = clog2(WIDTH)+1: width of the shift-amount and counter fields.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port in  in  WIDTH  parallel load data.
REQ-006 Port in_lsb  in  1  fill bit for left shifts in modes 00/11.
REQ-007 Port in_msb  in  1  fill bit for right shifts in modes 00/11.
REQ-008 Port load  in  1  parallel load request.
REQ-009 Port shift  in  1  single-step shift request.
REQ-010 Port start  in  1  multi-step shift request.
REQ-011 Port dir  in  1  0 = left, 1 = right.
REQ-012 Port mode  in  2  00 serial fill, 01 rotate, 10 arithmetic, 11 treated as 00.
REQ-013 Port amount  in  CNT_W  step count for start.
REQ-014 Port out  out  WIDTH  register contents.
REQ-015 Port ser_out  out  1  last bit shifted out, registered.
REQ-016 Port busy  out  1  multi-step run in progress.
REQ-017 Port done  out  1  one-cycle pulse at multi-step completion.

Function
REQ-018 Priority, sampled at each edge: load > start > shift > hold.
REQ-019 load SHALL set out<=in in any state, abort any run (busy<=0, no done), and leave ser_out unchanged.
REQ-020 One step, left: out<=(out<<1)|fill; fill = in_lsb (mode 00/11), out[WIDTH-1] (01), 0 (10). ser_out<=old out[WIDTH-1].
REQ-021 One step, right: out<=(out>>1) with MSB = in_msb (mode 00/11), out[0] (01), out[WIDTH-1] (10). ser_out<=old out[0].
REQ-022 shift in IDLE without load/start SHALL perform one step using the live dir/mode, with 1-cycle latency.
REQ-023 State machine: IDLE, RUN.
REQ-024 start in IDLE: latch dir and mode; load counter with min(amount, WIDTH); no step on that edge; go to RUN if count>0, else stay IDLE and assert done next cycle.
REQ-025 RUN: one step per edge using the latched dir/mode and the live fill bits; decrement the counter; on the edge of the final step go to IDLE and assert done for one cycle.
REQ-026 busy = (state==RUN); amount N>0 gives exactly N busy cycles, with done in cycle N+1.
REQ-027 In RUN, start and shift are ignored; changes to dir, mode and amount have no effect.
REQ-028 start in the same cycle as done (IDLE) SHALL begin a new run normally.

Reset
REQ-029 rst_n low SHALL immediately force out=0, ser_out=0, busy=0, done=0, counter=0, state=IDLE, independent of clk.
REQ-030 Reset mid-run SHALL abandon the run with no done pulse.
REQ-031 After rst_n rises, the first edge honours inputs normally.

Structure
REQ-032 Package bit_shift_pkg SHALL hold the mode encoding constants (MODE_FILL, MODE_ROT, MODE_ARITH) and the state enum.
REQ-033 No sub-modules are required; the single-step next-value logic SHALL be one function reused by the shift and RUN paths.

Verification (WIDTH=8)
REQ-034 Assert rst_n low mid-run -> out=0x00, busy=0, done=0, ser_out=0 without a clock edge.
REQ-035 Load 0xA5, then shift with dir=0, mode=00, in_lsb=1 -> out=0x4B, ser_out=1.
REQ-036 Load 0x81, start with dir=1, mode=01, amount=3 -> busy for 3 cycles, out=0x30, ser_out=0, done pulse in cycle 4.
REQ-037 Load 0x90, start with dir=1, mode=10, amount=2 -> out=0xE4, done once.
REQ-038 Start with amount=5 from 0xFF, then load 0x3C in the 2nd busy cycle -> out=0x3C, busy=0 next cycle, no done.
REQ-039 Amount=0 -> no busy, done next cycle, out unchanged; load 0xFF, start with amount=12, dir=0, mode=10 -> 8 busy cycles, out=0x00.
